// File: rtl/rate_tick_counter_pkg.sv
// Shared widths, rate-select encodings and rate load constants for the
// counter display lab time base.
package rate_tick_counter_pkg;

  localparam int unsigned RATE_W_DEF  = 20;
  localparam int unsigned DIGIT_W_DEF = 4;

  typedef enum logic [1:0] {
    RATE_FULL    = 2'b00,
    RATE_ONE     = 2'b01,
    RATE_HALF    = 2'b10,
    RATE_QUARTER = 2'b11
  } rate_sel_e;

  // Load values assume a 1 MHz time base; period = load + 1 cycles
  localparam logic [RATE_W_DEF-1:0] RATE_LOAD_FULL    = 20'd0;
  localparam logic [RATE_W_DEF-1:0] RATE_LOAD_ONE     = 20'd999_999;
  localparam logic [RATE_W_DEF-1:0] RATE_LOAD_HALF    = 20'd499_999;
  localparam logic [RATE_W_DEF-1:0] RATE_LOAD_QUARTER = 20'd249_999;

  function automatic logic [RATE_W_DEF-1:0] rate_load(input rate_sel_e sel);
    logic [RATE_W_DEF-1:0] val;
    case (sel)
      RATE_FULL:    val = RATE_LOAD_FULL;
      RATE_ONE:     val = RATE_LOAD_ONE;
      RATE_HALF:    val = RATE_LOAD_HALF;
      default:      val = RATE_LOAD_QUARTER;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/rate_tick_counter_gen.sv
// Reloadable down-counter: latches the rate load value and emits a
// registered one-cycle tick once every rate_q+1 enabled cycles.
module rate_tick_gen
  import rate_tick_counter_pkg::*;
#(
  parameter int unsigned RATE_W = RATE_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [RATE_W-1:0] rate_in,
  input  logic              enable,
  input  logic              restart,
  output logic              tick
);

  logic [RATE_W-1:0] rate_q, rate_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;

  always_comb begin
    rate_d = rate_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (restart) begin
      // restart reloads from the old rate; a pending change is taken next edge
      cnt_d = rate_q;
    end else if (rate_in != rate_q) begin
      rate_d = rate_in;
      cnt_d  = rate_in;
    end else if (enable) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        cnt_d  = rate_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rate_q <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      rate_q <= rate_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/rate_tick_counter.sv
// Time base for the counter display lab: tick generator plus a wrapping
// display-digit counter advanced by each tick.
module rate_tick_counter
  import rate_tick_counter_pkg::*;
#(
  parameter int unsigned RATE_W    = RATE_W_DEF,
  parameter int unsigned DIGIT_W   = DIGIT_W_DEF,
  parameter int unsigned DIGIT_MAX = 15
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [RATE_W-1:0]  rate_in,
  input  logic               enable,
  input  logic               clear,
  output logic               tick,
  output logic [DIGIT_W-1:0] digit
);

  logic               tick_w;
  logic [DIGIT_W-1:0] digit_q, digit_d;

  rate_tick_gen #(
    .RATE_W (RATE_W)
  ) u_gen (
    .clock   (clock),
    .resetn  (resetn),
    .rate_in (rate_in),
    .enable  (enable),
    .restart (clear),
    .tick    (tick_w)
  );

  always_comb begin
    digit_d = digit_q;
    if (clear) begin
      digit_d = '0;
    end else if (tick_w) begin
      digit_d = (digit_q == DIGIT_W'(DIGIT_MAX)) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign tick  = tick_w;
  assign digit = digit_q;

endmodule

// File: tb/tb_rate_tick_counter.sv
// Self-checking bench for rate_tick_counter against an elapsed-cycle model.
module tb_rate_tick_counter;

  localparam int unsigned RATE_W    = 20;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned DIGIT_MAX = 15;

  logic               clock;
  logic               resetn;
  logic [RATE_W-1:0]  rate_in;
  logic               enable;
  logic               clear;
  logic               tick;
  logic [DIGIT_W-1:0] digit;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: period length and enabled edges elapsed since the last reload
  int unsigned m_rate    = 0;
  int unsigned m_elapsed = 0;
  logic        m_tick    = 1'b0;
  int unsigned m_digit   = 0;

  rate_tick_counter #(
    .RATE_W    (RATE_W),
    .DIGIT_W   (DIGIT_W),
    .DIGIT_MAX (DIGIT_MAX)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .rate_in (rate_in),
    .enable  (enable),
    .clear   (clear),
    .tick    (tick),
    .digit   (digit)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic model_reset();
    m_rate = 0; m_elapsed = 0; m_tick = 1'b0; m_digit = 0;
  endtask

  // Advance one rising edge, update the model from the inputs seen there,
  // and return 1 time unit later so outputs can be sampled.
  task automatic step();
    @(posedge clock);
    if (!resetn) begin
      model_reset();
    end else begin
      if (clear) m_digit = 0;
      else if (m_tick) m_digit = (m_digit + 1) % (DIGIT_MAX + 1);
      if (clear) begin
        m_elapsed = 0; m_tick = 1'b0;
      end else if (int'(rate_in) != int'(m_rate)) begin
        m_rate = rate_in; m_elapsed = 0; m_tick = 1'b0;
      end else if (enable) begin
        m_elapsed++;
        if (m_elapsed == m_rate + 1) begin
          m_tick = 1'b1; m_elapsed = 0;
        end else begin
          m_tick = 1'b0;
        end
      end else begin
        m_tick = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; rate_in = 20'd3; enable = 1'b1; clear = 1'b0;
    #1;
    n_checks++;
    if (tick !== 1'b0 || digit !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state: tick=%0b digit=%0d required tick=0 digit=0", tick, digit);
    end
    step(); step();
    n_checks++;
    if (tick !== 1'b0 || digit !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_held: tick=%0b digit=%0d required tick=0 digit=0", tick, digit);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic_period();
    int unsigned first = 0, nticks = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++;
      if (tick !== m_tick || digit !== DIGIT_W'(m_digit)) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: tick=%0b digit=%0d required tick=%0b digit=%0d", k, tick, digit, m_tick, m_digit);
      end
      if (tick === 1'b1) begin
        nticks++;
        if (first == 0) first = k;
      end
    end
    n_checks++;
    if (first != 5 || nticks != 4) begin
      n_fail++;
      $display("FAIL basic_first_tick: edge=%0d count=%0d required edge=5 count=4", first, nticks);
    end
    n_checks++;
    if (digit !== 4'd4) begin
      n_fail++;
      $display("FAIL basic_digit: digit=%0d required 4", digit);
    end
  endtask

  task automatic test_rate_zero();
    int unsigned nticks = 0;
    rate_in = '0;
    step();
    for (int k = 1; k <= 40; k++) begin
      step();
      n_checks++;
      if (tick !== m_tick || digit !== DIGIT_W'(m_digit)) begin
        n_fail++;
        $display("FAIL rate0_cycle%0d: tick=%0b digit=%0d required tick=%0b digit=%0d", k, tick, digit, m_tick, m_digit);
      end
      if (tick === 1'b1) nticks++;
    end
    n_checks++;
    if (nticks != 40) begin
      n_fail++;
      $display("FAIL rate0_continuous: ticks=%0d required 40", nticks);
    end
  endtask

  task automatic test_enable_gap();
    int unsigned t1 = 0, t2 = 0;
    rate_in = 20'd5;
    step();
    for (int k = 1; k <= 16; k++) begin
      enable = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (tick !== m_tick || digit !== DIGIT_W'(m_digit)) begin
        n_fail++;
        $display("FAIL gap_cycle%0d: tick=%0b digit=%0d required tick=%0b digit=%0d", k, tick, digit, m_tick, m_digit);
      end
      if (tick === 1'b1) begin
        if (t1 == 0) t1 = k;
        else if (t2 == 0) t2 = k;
      end
    end
    enable = 1'b1;
    n_checks++;
    if (t1 != 9 || t2 != 15) begin
      n_fail++;
      $display("FAIL gap_tick_edges: first=%0d second=%0d required 9 15", t1, t2);
    end
  endtask

  task automatic test_rate_change();
    int unsigned t1 = 0, t2 = 0;
    rate_in = 20'd3;
    step();
    for (int k = 0; k < 20 && m_elapsed != 2; k++) step();
    n_checks++;
    if (m_elapsed != 2 || tick !== m_tick) begin
      n_fail++;
      $display("FAIL chg_setup: elapsed=%0d tick=%0b required elapsed=2 tick=%0b", m_elapsed, tick, m_tick);
    end
    rate_in = 20'd7;
    step();
    for (int k = 1; k <= 17; k++) begin
      step();
      n_checks++;
      if (tick !== m_tick || digit !== DIGIT_W'(m_digit)) begin
        n_fail++;
        $display("FAIL chg_cycle%0d: tick=%0b digit=%0d required tick=%0b digit=%0d", k, tick, digit, m_tick, m_digit);
      end
      if (tick === 1'b1) begin
        if (t1 == 0) t1 = k;
        else if (t2 == 0) t2 = k;
      end
    end
    n_checks++;
    if (t1 != 8 || t2 != 16) begin
      n_fail++;
      $display("FAIL chg_tick_edges: first=%0d second=%0d required 8 16", t1, t2);
    end
  endtask

  task automatic test_clear_with_change();
    int unsigned first = 0;
    rate_in = '0;
    for (int k = 0; k < 60 && !(m_digit == 9 && m_rate == 0 && m_tick); k++) step();
    n_checks++;
    if (digit !== 4'd9 || tick !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_setup: digit=%0d tick=%0b required digit=9 tick=1", digit, tick);
    end
    clear = 1'b1; rate_in = 20'd4;
    step();
    clear = 1'b0;
    n_checks++;
    if (digit !== 4'd0 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_edge: digit=%0d tick=%0b required digit=0 tick=0", digit, tick);
    end
    step();
    n_checks++;
    if (digit !== 4'd0 || tick !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_latch: digit=%0d tick=%0b required digit=0 tick=0", digit, tick);
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      n_checks++;
      if (tick !== m_tick || digit !== DIGIT_W'(m_digit)) begin
        n_fail++;
        $display("FAIL clr_cycle%0d: tick=%0b digit=%0d required tick=%0b digit=%0d", k, tick, digit, m_tick, m_digit);
      end
      if (tick === 1'b1 && first == 0) first = k;
    end
    n_checks++;
    if (first != 5) begin
      n_fail++;
      $display("FAIL clr_first_tick: edge=%0d required 5", first);
    end
  endtask

  task automatic test_random();
    logic prev_tick = tick;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(19) == 0) rate_in = RATE_W'($urandom_range(6));
      enable = ($urandom_range(9) < 8);
      clear  = ($urandom_range(24) == 0);
      step();
      n_checks++;
      if (tick !== m_tick || digit !== DIGIT_W'(m_digit)) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: tick=%0b digit=%0d required tick=%0b digit=%0d", k, tick, digit, m_tick, m_digit);
      end
      n_checks++;
      if (prev_tick === 1'b1 && tick === 1'b1 && m_rate != 0) begin
        n_fail++;
        $display("FAIL rand_double_tick%0d: tick=1 twice with rate=%0d required single", k, m_rate);
      end
      prev_tick = tick;
    end
    clear = 1'b0; enable = 1'b1;
  endtask

  task automatic test_async_reset();
    rate_in = '0;
    for (int k = 0; k < 10 && !(m_tick && m_digit != 0); k++) step();
    n_checks++;
    if (tick !== 1'b1 || digit === 4'd0) begin
      n_fail++;
      $display("FAIL areset_setup: tick=%0b digit=%0d required tick=1 digit!=0", tick, digit);
    end
    #2 resetn = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (tick !== 1'b0 || digit !== 4'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: tick=%0b digit=%0d required tick=0 digit=0", tick, digit);
    end
    step();
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_checks++;
      if (tick !== m_tick || digit !== DIGIT_W'(m_digit)) begin
        n_fail++;
        $display("FAIL areset_cycle%0d: tick=%0b digit=%0d required tick=%0b digit=%0d", k, tick, digit, m_tick, m_digit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_period();
    test_rate_zero();
    test_enable_gap();
    test_rate_change();
    test_clear_with_change();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
